// File: rtl/rv_fetch_pkg.sv
// rtl/rv_fetch_pkg.sv - shared constants for the instruction-fetch front end
package rv_fetch_pkg;
  localparam int          XLEN             = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] PC_STEP          = 32'd4;
endpackage

// File: rtl/pc_fetch_unit_if.sv
// rtl/pc_fetch_unit_if.sv - fetch unit control, memory and IF/ID bundle
interface pc_fetch_unit_if;
  import rv_fetch_pkg::*;

  logic            stall;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_target;
  logic [XLEN-1:0] instruction;
  logic [XLEN-1:0] PCs;
  logic            if_id_valid;
  logic [XLEN-1:0] if_id_pc;
  logic [XLEN-1:0] if_id_pc_plus4;
  logic [XLEN-1:0] if_id_instruction;
  logic            misaligned_redirect;
  logic [31:0]     fetch_count;

  modport master (
    input  stall, redirect_valid, redirect_target, instruction,
    output PCs, if_id_valid, if_id_pc, if_id_pc_plus4, if_id_instruction,
           misaligned_redirect, fetch_count
  );

  modport slave (
    output stall, redirect_valid, redirect_target, instruction,
    input  PCs, if_id_valid, if_id_pc, if_id_pc_plus4, if_id_instruction,
           misaligned_redirect, fetch_count
  );
endinterface

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register with flush and NOP substitution
module if_id_reg #(
  parameter logic [31:0] RESET_PC  = rv_fetch_pkg::RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = rv_fetch_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_i,
  input  logic        flush_i,
  input  logic        hold_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] instr_i,
  output logic        valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  output logic [31:0] instr_o
);
  import rv_fetch_pkg::*;

  logic        valid_q, valid_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_plus4_q, pc_plus4_d;
  logic [31:0] instr_q, instr_d;

  always_comb begin
    valid_d    = valid_q;
    pc_d       = pc_q;
    pc_plus4_d = pc_plus4_q;
    instr_d    = instr_q;
    // Flush keeps pc/pc_plus4 so decode still sees the last real address.
    if (flush_i) begin
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
    end else if (load_i && !hold_i) begin
      valid_d    = 1'b1;
      pc_d       = pc_i;
      pc_plus4_d = pc_i + PC_STEP;
      instr_d    = instr_i;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q    <= 1'b0;
      pc_q       <= '0;
      pc_plus4_q <= RESET_PC + PC_STEP;
      instr_q    <= NOP_INSTR;
    end else begin
      valid_q    <= valid_d;
      pc_q       <= pc_d;
      pc_plus4_q <= pc_plus4_d;
      instr_q    <= instr_d;
    end
  end

  assign valid_o    = valid_q;
  assign pc_o       = pc_q;
  assign pc_plus4_o = pc_plus4_q;
  assign instr_o    = valid_q ? instr_q : NOP_INSTR;
endmodule

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - program counter, next-PC select, misalign flag and fetch counter
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC  = rv_fetch_pkg::RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = rv_fetch_pkg::NOP_INSTR
) (
  input logic            clk,
  input logic            reset,
  pc_fetch_unit_if.master fif
);
  import rv_fetch_pkg::*;

  logic [XLEN-1:0] pc_q, pc_d;
  logic            mis_q, mis_d;
  logic [31:0]     cnt_q, cnt_d;
  logic            load, flush, hold;

  // Priority: redirect beats stall, stall beats advance.
  always_comb begin
    pc_d  = pc_q;
    mis_d = 1'b0;
    cnt_d = cnt_q;
    load  = 1'b0;
    flush = 1'b0;
    hold  = 1'b0;
    if (fif.redirect_valid) begin
      pc_d  = {fif.redirect_target[XLEN-1:2], 2'b00};
      mis_d = |fif.redirect_target[1:0];
      flush = 1'b1;
    end else if (fif.stall) begin
      hold = 1'b1;
    end else begin
      pc_d  = pc_q + PC_STEP;
      cnt_d = cnt_q + 32'd1;
      load  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q  <= RESET_PC;
      mis_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      pc_q  <= pc_d;
      mis_q <= mis_d;
      cnt_q <= cnt_d;
    end
  end

  if_id_reg #(
    .RESET_PC  (RESET_PC),
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk        (clk),
    .reset      (reset),
    .load_i     (load),
    .flush_i    (flush),
    .hold_i     (hold),
    .pc_i       (pc_q),
    .instr_i    (fif.instruction),
    .valid_o    (fif.if_id_valid),
    .pc_o       (fif.if_id_pc),
    .pc_plus4_o (fif.if_id_pc_plus4),
    .instr_o    (fif.if_id_instruction)
  );

  assign fif.PCs                 = pc_q;
  assign fif.misaligned_redirect = mis_q;
  assign fif.fetch_count         = cnt_q;
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - directed scoreboard bench for pc_fetch_unit
module tb_pc_fetch_unit;
  logic clk = 1'b0;
  logic reset_a;
  logic reset_b;

  pc_fetch_unit_if fa ();
  pc_fetch_unit_if fb ();

  always #5 clk = ~clk;

  // Instruction memory returns its own address as data.
  assign fa.instruction = fa.PCs;
  assign fb.instruction = fb.PCs;

  pc_fetch_unit #(.RESET_PC(32'h0000_0000), .NOP_INSTR(32'h0000_0013)) dut_a (
    .clk   (clk),
    .reset (reset_a),
    .fif   (fa)
  );

  pc_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .NOP_INSTR(32'h0000_0013)) dut_b (
    .clk   (clk),
    .reset (reset_b),
    .fif   (fb)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        sb_q[$];
  int          tests_run    = 0;
  int          tests_failed = 0;
  logic [31:0] exp_pc;
  logic [31:0] exp_cnt;
  logic [31:0] exp_ifid_pc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests_run++;
    assert (obs === expv) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_a(input string tag);
    check({tag, "_PCs"},   fa.PCs, 32'h0);
    check({tag, "_valid"}, {31'b0, fa.if_id_valid}, 32'h0);
    check({tag, "_pc"},    fa.if_id_pc, 32'h0);
    check({tag, "_pc4"},   fa.if_id_pc_plus4, 32'h4);
    check({tag, "_instr"}, fa.if_id_instruction, 32'h13);
    check({tag, "_mis"},   {31'b0, fa.misaligned_redirect}, 32'h0);
    check({tag, "_cnt"},   fa.fetch_count, 32'h0);
  endtask

  task automatic advance_a();
    exp_t e;
    e.pc    = exp_pc;
    e.instr = exp_pc;
    sb_q.push_back(e);
    fa.stall          = 1'b0;
    fa.redirect_valid = 1'b0;
    step();
    e           = sb_q.pop_front();
    exp_pc      = exp_pc + 32'd4;
    exp_cnt     = exp_cnt + 32'd1;
    exp_ifid_pc = e.pc;
    check("adv_ifid_pc",    fa.if_id_pc, e.pc);
    check("adv_ifid_instr", fa.if_id_instruction, e.instr);
    check("adv_ifid_pc4",   fa.if_id_pc_plus4, e.pc + 32'd4);
    check("adv_valid",      {31'b0, fa.if_id_valid}, 32'h1);
    check("adv_PCs",        fa.PCs, exp_pc);
    check("adv_cnt",        fa.fetch_count, exp_cnt);
    check("adv_mis",        {31'b0, fa.misaligned_redirect}, 32'h0);
  endtask

  task automatic redirect_a(input logic [31:0] target, input logic with_stall);
    fa.redirect_valid  = 1'b1;
    fa.redirect_target = target;
    fa.stall           = with_stall;
    step();
    fa.redirect_valid = 1'b0;
    fa.stall          = 1'b0;
    exp_pc = {target[31:2], 2'b00};
    check("rd_PCs",   fa.PCs, exp_pc);
    check("rd_valid", {31'b0, fa.if_id_valid}, 32'h0);
    check("rd_instr", fa.if_id_instruction, 32'h13);
    check("rd_pc",    fa.if_id_pc, exp_ifid_pc);
    check("rd_pc4",   fa.if_id_pc_plus4, exp_ifid_pc + 32'd4);
    check("rd_mis",   {31'b0, fa.misaligned_redirect}, {31'b0, |target[1:0]});
    check("rd_cnt",   fa.fetch_count, exp_cnt);
  endtask

  initial begin
    reset_a            = 1'b0;
    reset_b            = 1'b0;
    fa.stall           = 1'b0;
    fa.redirect_valid  = 1'b0;
    fa.redirect_target = 32'h0;
    fb.stall           = 1'b0;
    fb.redirect_valid  = 1'b0;
    fb.redirect_target = 32'h0;
    exp_pc      = 32'h0;
    exp_cnt     = 32'h0;
    exp_ifid_pc = 32'h0;

    step();
    step();
    check_reset_a("rst");
    check("rstb_PCs", fb.PCs, 32'hFFFF_FFF8);
    check("rstb_pc4", fb.if_id_pc_plus4, 32'hFFFF_FFFC);

    reset_a = 1'b1;
    repeat (3) advance_a();

    // Stall with PCs=12: everything holds.
    fa.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_PCs",   fa.PCs, 32'd12);
      check("stall_pc",    fa.if_id_pc, 32'd8);
      check("stall_cnt",   fa.fetch_count, 32'd3);
      check("stall_valid", {31'b0, fa.if_id_valid}, 32'h1);
    end
    fa.stall = 1'b0;
    repeat (2) advance_a();
    check("seq_cnt5", fa.fetch_count, 32'd5);
    check("seq_PCs20", fa.PCs, 32'd20);

    redirect_a(32'h40, 1'b0);
    advance_a();
    check("post_rd_pc", fa.if_id_pc, 32'h40);

    redirect_a(32'h46, 1'b1);
    advance_a();
    check("post_mis_pc", fa.if_id_pc, 32'h44);

    // Back-to-back redirects, then a stall keeps the bubble.
    redirect_a(32'h100, 1'b0);
    redirect_a(32'h203, 1'b0);
    fa.stall = 1'b1;
    step();
    fa.stall = 1'b0;
    check("b2b_stall_valid", {31'b0, fa.if_id_valid}, 32'h0);
    check("b2b_stall_PCs",   fa.PCs, 32'h200);
    check("b2b_stall_mis",   {31'b0, fa.misaligned_redirect}, 32'h0);
    advance_a();

    redirect_a(32'h1C, 1'b0);
    advance_a();
    check("pre_async_PCs", fa.PCs, 32'h20);

    // Reset asserted between edges must act before the next edge.
    #2;
    reset_a = 1'b0;
    #1;
    check_reset_a("async");

    // Wrap-around from RESET_PC=FFFFFFF8.
    reset_b = 1'b1;
    step();
    check("wrap1_pc",  fb.if_id_pc, 32'hFFFF_FFF8);
    check("wrap1_PCs", fb.PCs, 32'hFFFF_FFFC);
    step();
    check("wrap2_pc",    fb.if_id_pc, 32'hFFFF_FFFC);
    check("wrap2_pc4",   fb.if_id_pc_plus4, 32'h0);
    check("wrap2_instr", fb.if_id_instruction, 32'hFFFF_FFFC);
    check("wrap2_PCs",   fb.PCs, 32'h0);
    step();
    check("wrap3_pc",  fb.if_id_pc, 32'h0);
    check("wrap3_PCs", fb.PCs, 32'h4);
    check("wrap3_cnt", fb.fetch_count, 32'd3);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
